// File: rtl/sdfm_sinc_bank.sv
// N-channel sinc1/2/3 decimation filter bank for sigma-delta modulator streams.
// Per-channel synchronisers and CIC filters feed holding registers, which a round-robin arbiter merges into one tagged FIFO.
module sdfm_sinc_bank #(
    parameter int NCH        = 2,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 8,
    localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int LVW       = AW + 1
) (
    input  logic            EXTCLK,
    input  logic            EXTRST,
    input  logic [NCH-1:0]  EN,
    input  logic [1:0]      ORDER,
    input  logic [7:0]      OSR_M1,
    input  logic [NCH-1:0]  DSDIN,
    input  logic [NCH-1:0]  SDCLK,
    input  logic            RDY,
    output logic            VLD,
    output logic [DW-1:0]   DOUT,
    output logic [CHW-1:0]  DCH,
    output logic [LVW-1:0]  LEVEL,
    output logic [NCH-1:0]  OVF,
    input  logic [NCH-1:0]  OVF_CLR
);

    function automatic logic [DW-1:0] f_tap(input logic [1:0] k, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [DW-1:0] c);
        case (k)
            2'd1:    f_tap = a;
            2'd2:    f_tap = b;
            2'd3:    f_tap = c;
            default: f_tap = '0;
        endcase
    endfunction

    logic [NCH-1:0] r_sck_p0, r_sck_p1, r_sck_p2;
    logic [NCH-1:0] r_dsd_p0, r_dsd_p1;
    logic [1:0]     r_order_q;
    logic [7:0]     r_osr_q;
    logic [NCH-1:0] r_en_q;

    logic [DW-1:0]  r_i1 [NCH];
    logic [DW-1:0]  r_i2 [NCH];
    logic [DW-1:0]  r_i3 [NCH];
    logic [DW-1:0]  r_d1 [NCH];
    logic [DW-1:0]  r_d2 [NCH];
    logic [DW-1:0]  r_d3 [NCH];
    logic [7:0]     r_cnt [NCH];
    logic [1:0]     r_disc [NCH];
    logic [DW-1:0]  r_hold [NCH];
    logic [NCH-1:0] r_dec_p2;
    logic [NCH-1:0] r_pend;
    logic [NCH-1:0] r_ovf;
    logic [CHW-1:0] r_rr;

    logic [DW-1:0]  r_mem_d [FIFO_DEPTH];
    logic [CHW-1:0] r_mem_c [FIFO_DEPTH];
    logic [AW-1:0]  r_wp, r_rp;
    logic [LVW-1:0] r_level;

    logic [NCH-1:0] w_stb, w_clr, w_load, w_gnt;
    logic           w_cfg_chg;
    logic [DW-1:0]  w_i1n [NCH];
    logic [DW-1:0]  w_i2n [NCH];
    logic [DW-1:0]  w_i3n [NCH];
    logic [DW-1:0]  w_cin [NCH];
    logic [DW-1:0]  w_c1 [NCH];
    logic [DW-1:0]  w_c2 [NCH];
    logic [DW-1:0]  w_c3 [NCH];
    logic [DW-1:0]  w_cout [NCH];
    logic           w_push, w_pop, w_room;
    logic [CHW-1:0] w_gnt_idx;
    int             w_c;

    assign w_stb     = r_sck_p1 & ~r_sck_p2;
    assign w_cfg_chg = (ORDER != r_order_q) || (OSR_M1 != r_osr_q);
    // ORDER=00 and a disabled channel both pin the filter in its cleared state.
    assign w_clr     = {NCH{w_cfg_chg || (ORDER == 2'd0)}} | ~EN | (EN & ~r_en_q);

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_i1n[i]  = r_i1[i] + {{(DW-1){1'b0}}, r_dsd_p1[i]};
            w_i2n[i]  = r_i2[i] + w_i1n[i];
            w_i3n[i]  = r_i3[i] + w_i2n[i];
            w_cin[i]  = f_tap(r_order_q, r_i1[i], r_i2[i], r_i3[i]);
            w_c1[i]   = w_cin[i] - r_d1[i];
            w_c2[i]   = w_c1[i] - r_d2[i];
            w_c3[i]   = w_c2[i] - r_d3[i];
            w_cout[i] = f_tap(r_order_q, w_c1[i], w_c2[i], w_c3[i]);
            w_load[i] = r_dec_p2[i] && (r_disc[i] == 2'd0) && !w_clr[i];
        end
    end

    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_push    = 1'b0;
        w_c       = 0;
        w_pop     = RDY && (r_level != '0);
        w_room    = (r_level != LVW'(FIFO_DEPTH)) || w_pop;
        for (int k = 0; k < NCH; k++) begin
            w_c = int'(r_rr) + k;
            if (w_c >= NCH) w_c = w_c - NCH;
            if (!w_push && w_room && r_pend[CHW'(w_c)]) begin
                w_push    = 1'b1;
                w_gnt_idx = CHW'(w_c);
            end
        end
        if (w_push) w_gnt[w_gnt_idx] = 1'b1;
    end

    // Edges 0-1: synchronisers; edge 2: integrate/count; edge 3: comb and hold.
    always_ff @(posedge EXTCLK) begin
        if (EXTRST) begin
            r_sck_p0  <= '0;
            r_sck_p1  <= '0;
            r_sck_p2  <= '0;
            r_dsd_p0  <= '0;
            r_dsd_p1  <= '0;
            r_order_q <= '0;
            r_osr_q   <= '0;
            r_en_q    <= '0;
            r_dec_p2  <= '0;
            r_pend    <= '0;
            r_ovf     <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_i1[i]   <= '0;
                r_i2[i]   <= '0;
                r_i3[i]   <= '0;
                r_d1[i]   <= '0;
                r_d2[i]   <= '0;
                r_d3[i]   <= '0;
                r_cnt[i]  <= '0;
                r_disc[i] <= '0;
                r_hold[i] <= '0;
            end
        end else begin
            r_sck_p0  <= SDCLK;
            r_sck_p1  <= r_sck_p0;
            r_sck_p2  <= r_sck_p1;
            r_dsd_p0  <= DSDIN;
            r_dsd_p1  <= r_dsd_p0;
            r_order_q <= ORDER;
            r_osr_q   <= OSR_M1;
            r_en_q    <= EN;
            r_pend    <= w_load | (r_pend & ~w_gnt);
            r_ovf     <= (r_ovf & ~OVF_CLR) | (w_load & r_pend & ~w_gnt);
            for (int i = 0; i < NCH; i++) begin
                if (w_clr[i]) begin
                    r_i1[i]     <= '0;
                    r_i2[i]     <= '0;
                    r_i3[i]     <= '0;
                    r_d1[i]     <= '0;
                    r_d2[i]     <= '0;
                    r_d3[i]     <= '0;
                    r_cnt[i]    <= '0;
                    r_dec_p2[i] <= 1'b0;
                    r_disc[i]   <= ORDER;
                end else begin
                    r_dec_p2[i] <= 1'b0;
                    if (w_stb[i]) begin
                        r_i1[i] <= w_i1n[i];
                        r_i2[i] <= w_i2n[i];
                        r_i3[i] <= w_i3n[i];
                        if (r_cnt[i] == r_osr_q) begin
                            r_cnt[i]    <= '0;
                            r_dec_p2[i] <= 1'b1;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 8'd1;
                        end
                    end
                    if (r_dec_p2[i]) begin
                        r_d1[i] <= w_cin[i];
                        r_d2[i] <= w_c1[i];
                        r_d3[i] <= w_c2[i];
                        if (r_disc[i] != 2'd0) r_disc[i] <= r_disc[i] - 2'd1;
                    end
                end
                if (w_load[i]) r_hold[i] <= w_cout[i];
            end
        end
    end

    // Edge 4: arbitration result enters the FIFO.
    always_ff @(posedge EXTCLK) begin
        if (EXTRST) begin
            r_rr    <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_rr <= (w_gnt_idx == CHW'(NCH - 1)) ? '0 : w_gnt_idx + CHW'(1);
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) r_rp <= r_rp + AW'(1);
            if (w_push && !w_pop)      r_level <= r_level + LVW'(1);
            else if (!w_push && w_pop) r_level <= r_level - LVW'(1);
        end
    end

    always_ff @(posedge EXTCLK) begin
        if (w_push) begin
            r_mem_d[r_wp] <= r_hold[w_gnt_idx];
            r_mem_c[r_wp] <= w_gnt_idx;
        end
    end

    assign VLD   = (r_level != '0);
    assign DOUT  = VLD ? r_mem_d[r_rp] : '0;
    assign DCH   = VLD ? r_mem_c[r_rp] : '0;
    assign LEVEL = r_level;
    assign OVF   = r_ovf;

endmodule

// File: tb/tb_sdfm_sinc_bank.sv
// Bench for sdfm_sinc_bank: table of filter configurations plus hand-written multi-cycle sequences,
// with a scoreboard queue of expected {value, channel} results checked on every FIFO pop.
`timescale 1ns/1ps
module tb_sdfm_sinc_bank;
    localparam int NCH = 2;
    localparam int DW  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    EN, DSDIN, SDCLK, OVF_CLR, OVF;
    logic [1:0]    ORDER;
    logic [7:0]    OSR_M1;
    logic          RDY, VLD;
    logic [DW-1:0] DOUT;
    logic [0:0]    DCH;
    logic [3:0]    LEVEL;

    sdfm_sinc_bank #(.NCH(NCH), .DW(DW), .FIFO_DEPTH(8)) dut (
        .EXTCLK(clk), .EXTRST(rst), .EN(EN), .ORDER(ORDER), .OSR_M1(OSR_M1),
        .DSDIN(DSDIN), .SDCLK(SDCLK), .RDY(RDY), .VLD(VLD), .DOUT(DOUT),
        .DCH(DCH), .LEVEL(LEVEL), .OVF(OVF), .OVF_CLR(OVF_CLR)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] d; int ch; } exp_t;
    typedef struct {
        logic [1:0] order; logic [7:0] osr; logic [1:0] en;
        int p0; int p1; int nedges; int nres; logic [DW-1:0] val; int ch;
    } vec_t;

    exp_t sb[$];
    exp_t m_e;
    vec_t tbl [10];
    int   n_cmp = 0;
    int   n_err = 0;
    int   rr_m  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input int ch);
        exp_t e;
        e.d  = d;
        e.ch = ch;
        sb.push_back(e);
        rr_m = (ch + 1) % NCH;
    endtask

    task automatic push_pair(input logic [DW-1:0] d);
        if (rr_m == 0) begin push_exp(d, 0); push_exp(d, 1); end
        else           begin push_exp(d, 1); push_exp(d, 0); end
    endtask

    function automatic logic bitpat(input int p, input int j);
        if (p == 1) return 1'b1;
        if (p == 2) return ~j[0];
        return 1'b0;
    endfunction

    task automatic sd_edges(input int n, input logic [1:0] mask, input int p0, input int p1);
        for (int j = 0; j < n; j++) begin
            DSDIN[0] = bitpat(p0, j);
            DSDIN[1] = bitpat(p1, j);
            SDCLK    = mask;
            tick(3);
            SDCLK    = 2'b00;
            tick(3);
        end
    endtask

    task automatic restart(input logic [1:0] order, input logic [7:0] osr, input logic [1:0] en);
        EN = 2'b00;
        tick(4);
        ORDER  = order;
        OSR_M1 = osr;
        tick(4);
        EN = en;
        tick(4);
    endtask

    always @(negedge clk) begin
        if (!rst && VLD && RDY) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got DOUT=%0d DCH=%0d, expected no result", DOUT, DCH);
            end else begin
                m_e = sb.pop_front();
                check("dout", DOUT, m_e.d);
                check("dch", DCH, m_e.ch);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'd3, 8'd15,  2'b01, 1, 0, 80,   2, 32'd4096,     0};
        tbl[1] = '{2'd2, 8'd15,  2'b10, 0, 2, 64,   2, 32'd128,      1};
        tbl[2] = '{2'd1, 8'd15,  2'b01, 1, 0, 64,   3, 32'd16,       0};
        tbl[3] = '{2'd3, 8'd7,   2'b10, 0, 1, 40,   2, 32'd512,      1};
        tbl[4] = '{2'd2, 8'd0,   2'b01, 1, 0, 5,    3, 32'd1,        0};
        tbl[5] = '{2'd1, 8'd255, 2'b10, 0, 1, 512,  1, 32'd256,      1};
        tbl[6] = '{2'd3, 8'd255, 2'b01, 1, 0, 1024, 1, 32'd16777216, 0};
        tbl[7] = '{2'd3, 8'd15,  2'b01, 0, 0, 80,   2, 32'd0,        0};
        tbl[8] = '{2'd0, 8'd15,  2'b11, 1, 1, 64,   0, 32'd0,        0};
        tbl[9] = '{2'd2, 8'd15,  2'b10, 0, 1, 48,   1, 32'd256,      1};

        // Reset with modulator activity present
        rst = 1'b1; EN = 2'b01; ORDER = 2'd3; OSR_M1 = 8'd15;
        DSDIN = 2'b11; SDCLK = 2'b00; RDY = 1'b1; OVF_CLR = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            SDCLK = ~SDCLK;
            @(negedge clk);
            check($sformatf("rst_vld_%0d", c), VLD, 0);
            check($sformatf("rst_level_%0d", c), LEVEL, 0);
            check($sformatf("rst_ovf_%0d", c), OVF, 0);
            check($sformatf("rst_dout_dch_%0d", c), {DOUT, DCH}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        SDCLK = 2'b00;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check($sformatf("post_rst_quiet_%0d", c), {VLD, LEVEL, OVF}, 0);
        end
        tick(1);

        // sinc3, OSR 16, ch0 all ones straight after reset
        for (int k = 0; k < 2; k++) push_exp(32'd4096, 0);
        sd_edges(80, 2'b01, 1, 0);
        tick(20);
        check("after_reset_sinc3_drain", sb.size(), 0);

        for (int r = 0; r < 10; r++) begin
            restart(tbl[r].order, tbl[r].osr, tbl[r].en);
            for (int k = 0; k < tbl[r].nres; k++) push_exp(tbl[r].val, tbl[r].ch);
            sd_edges(tbl[r].nedges, tbl[r].en, tbl[r].p0, tbl[r].p1);
            tick(20);
            check($sformatf("row%0d_drain", r), sb.size(), 0);
        end

        // Two channels on one SDCLK: simultaneous results, round-robin tags
        restart(2'd1, 8'd15, 2'b11);
        for (int k = 0; k < 3; k++) push_pair(32'd16);
        sd_edges(64, 2'b11, 1, 1);
        tick(20);
        check("pair_drain", sb.size(), 0);

        // Backpressure: fill FIFO, hold, overwrite, clear, drain
        RDY = 1'b0;
        restart(2'd1, 8'd15, 2'b11);
        sd_edges(80, 2'b11, 1, 1);
        tick(10);
        check("bp_full_level", LEVEL, 8);
        check("bp_full_ovf", OVF, 0);
        sd_edges(16, 2'b11, 1, 1);
        tick(10);
        check("bp_held_level", LEVEL, 8);
        check("bp_held_ovf", OVF, 0);
        sd_edges(16, 2'b11, 1, 1);
        tick(10);
        check("bp_ovf_level", LEVEL, 8);
        check("bp_ovf_set", OVF, 2'b11);
        OVF_CLR = 2'b01;
        tick(1);
        OVF_CLR = 2'b00;
        @(negedge clk);
        check("bp_ovf_clr", OVF, 2'b10);
        for (int k = 0; k < 5; k++) push_pair(32'd16);
        tick(1);
        RDY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_push_pop_full", LEVEL, 8);
        tick(20);
        check("bp_drain", sb.size(), 0);
        check("bp_level_empty", LEVEL, 0);
        check("bp_ovf_kept", OVF, 2'b10);

        // OSR change mid-window restarts without a partial result
        restart(2'd3, 8'd15, 2'b01);
        push_exp(32'd4096, 0);
        sd_edges(72, 2'b01, 1, 0);
        tick(10);
        check("osr_chg_before", sb.size(), 0);
        OSR_M1 = 8'd7;
        tick(4);
        for (int k = 0; k < 2; k++) push_exp(32'd512, 0);
        sd_edges(40, 2'b01, 1, 0);
        tick(20);
        check("osr_chg_after", sb.size(), 0);
        check("final_vld", VLD, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
